// File: rtl/command_frame_parser.sv
// command_frame_parser: turns decoded UART characters into peripheral register writes.
// Build option CMD_CHECKSUM_EN: each frame carries a trailing zero-sum checksum byte.
`timescale 1ns/1ps
module command_frame_parser #(
  parameter int MAX_DATA = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_drdy,
  input  logic [7:0] char_data,
  input  logic       char_start,
  input  logic       char_end,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [7:0] wr_periph,
  output logic [7:0] wr_reg,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

`ifdef CMD_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  localparam int DEPTH = MAX_DATA + CHK;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PERIPH,
    S_REG,
    S_DATA,
    S_REPLAY
  } state_e;

  state_e        state_q, state_d;
  logic          drdy_q;
  logic          ev;
  logic [7:0]    periph_q, periph_d;
  logic [7:0]    reg_q, reg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] n_q, n_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          we;
  logic          chk_ok;
  logic [7:0]    mem_q [2**AW];

  assign ev = char_drdy & ~drdy_q;

`ifdef CMD_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  // Running sum covers periph, reg and every buffered byte incl. checksum.
  always_comb begin
    sum_d = sum_q;
    if (ev && !char_start && !char_end) begin
      if (state_q == S_PERIPH) begin
        sum_d = char_data;
      end else if (state_q == S_REG || we) begin
        sum_d = sum_q + char_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign chk_ok = (sum_q == 8'h00);
`else
  assign chk_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    periph_d = periph_q;
    reg_d    = reg_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    n_d      = n_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    we       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ev && char_start) begin
          state_d = S_PERIPH;
        end
      end
      S_PERIPH, S_REG, S_DATA: begin
        if (ev) begin
          if (char_start) begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = S_PERIPH;
          end else if (char_end) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = 2'd0;
            // Need at least one data byte beyond the optional checksum.
            if (state_q == S_DATA && cnt_q > CW'(CHK)) begin
              if (chk_ok) begin
                err_d   = 1'b0;
                state_d = S_REPLAY;
                idx_d   = '0;
                n_d     = cnt_q - CW'(CHK);
              end else begin
                code_d = 2'd3;
              end
            end
          end else if (state_q == S_PERIPH) begin
            periph_d = char_data;
            state_d  = S_REG;
          end else if (state_q == S_REG) begin
            reg_d   = char_data;
            cnt_d   = '0;
            state_d = S_DATA;
          end else if (cnt_q == CW'(DEPTH)) begin
            err_d   = 1'b1;
            code_d  = 2'd2;
            state_d = S_IDLE;
          end else begin
            we    = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_REPLAY: begin
        if (wr_ready) begin
          idx_d = idx_q + CW'(1);
          if (idx_q + CW'(1) == n_q) begin
            state_d = S_IDLE;
            ok_d    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      drdy_q   <= 1'b0;
      periph_q <= 8'h00;
      reg_q    <= 8'h00;
      cnt_q    <= '0;
      idx_q    <= '0;
      n_q      <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      drdy_q   <= char_drdy;
      periph_q <= periph_d;
      reg_q    <= reg_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[cnt_q[AW-1:0]] <= char_data;
    end
  end

  assign wr_valid  = (state_q == S_REPLAY);
  assign busy      = (state_q != S_IDLE);
  assign wr_periph = wr_valid ? periph_q : 8'h00;
  assign wr_reg    = wr_valid ? reg_q + 8'(idx_q) : 8'h00;
  assign wr_data   = wr_valid ? mem_q[idx_q[AW-1:0]] : 8'h00;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_command_frame_parser.sv
// tb_command_frame_parser: directed and randomized frames against a queue-based frame model.
// Follows CMD_CHECKSUM_EN the same way the design does.
`timescale 1ns/1ps
module tb_command_frame_parser;

  localparam int MAX_DATA = 16;
`ifdef CMD_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  localparam int DEPTH = MAX_DATA + CHK;

  logic       clk = 1'b0;
  logic       reset;
  logic       char_drdy;
  logic [7:0] char_data;
  logic       char_start;
  logic       char_end;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_periph;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;
  logic       busy;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  command_frame_parser #(.MAX_DATA(MAX_DATA)) dut (
    .clk(clk),
    .reset(reset),
    .char_drdy(char_drdy),
    .char_data(char_data),
    .char_start(char_start),
    .char_end(char_end),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_periph(wr_periph),
    .wr_reg(wr_reg),
    .wr_data(wr_data),
    .busy(busy),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit          in_frame;
  logic [7:0]  cur[$];
  logic [23:0] exp_w[$];
  logic [23:0] got_w[$];
  int          exp_ok, got_ok, exp_ec, got_ec;
  int          rdy_mode;
  bit          auto_wait;
  bit          rand_hold;
  logic [9:0]  seq[$];

  localparam logic [9:0] ST = 10'h200;
  localparam logic [9:0] EN = 10'h100;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tally_clear();
    exp_w.delete();
    got_w.delete();
    exp_ok = 0;
    got_ok = 0;
    exp_ec = 0;
    got_ec = 0;
  endtask

  task automatic tally_check(input string tag);
    chk({tag, "_nwr"}, got_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      chk({tag, "_wr"}, 32'(got_w[i]), 32'(exp_w[i]));
    chk({tag, "_ok"}, got_ok, exp_ok);
    chk({tag, "_err"}, got_ec, exp_ec);
    tally_clear();
  endtask

  // Frame-level model: bytes since START kept in a queue, judged at END.
  task automatic model_char(input logic [9:0] c, output bit e,
                            output logic [1:0] code, output bit rep);
    int n;
    logic [7:0] s;
    e = 1'b0;
    code = 2'd0;
    rep = 1'b0;
    if (c[9]) begin
      if (in_frame) begin
        e = 1'b1;
        code = 2'd1;
      end
      in_frame = 1'b1;
      cur.delete();
    end else if (c[8]) begin
      if (in_frame) begin
        in_frame = 1'b0;
        n = cur.size() - 2 - CHK;
        s = 8'h00;
        foreach (cur[i]) s = s + cur[i];
        if (n < 1) begin
          e = 1'b1;
          code = 2'd0;
        end else if (CHK == 1 && s != 8'h00) begin
          e = 1'b1;
          code = 2'd3;
        end else begin
          rep = 1'b1;
          for (int i = 0; i < n; i++)
            exp_w.push_back({cur[0], 8'(cur[1] + 8'(i)), cur[2+i]});
        end
      end
    end else if (in_frame) begin
      if (cur.size() == 2 + DEPTH) begin
        e = 1'b1;
        code = 2'd2;
        in_frame = 1'b0;
      end else begin
        cur.push_back(c[7:0]);
      end
    end
    if (e) exp_ec++;
    if (rep) exp_ok++;
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    chk({tag, "_idle_timeout"}, 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic play_char(input logic [9:0] c, input int hold);
    bit e, rep;
    logic [1:0] code;
    @(posedge clk); #1;
    {char_start, char_end, char_data} = c;
    char_drdy = 1'b1;
    @(posedge clk);
    model_char(c, e, code, rep);
    @(negedge clk);
    chk("frame_err", 32'(frame_err), 32'(e));
    if (e) chk("err_code", 32'(err_code), 32'(code));
    chk("busy", 32'(busy), 32'(in_frame | rep));
    chk("wr_valid", 32'(wr_valid), 32'(rep));
    for (int k = 1; k < hold; k++) begin
      @(posedge clk); #1;
      {char_start, char_end, char_data} = 10'($urandom);
    end
    @(posedge clk); #1;
    char_drdy = 1'b0;
    {char_start, char_end, char_data} = 10'h000;
    if (rep && auto_wait) wait_idle("replay");
  endtask

  task automatic play_seq();
    foreach (seq[i])
      play_char(seq[i], rand_hold ? int'($urandom_range(1, 3)) : 1);
    seq.delete();
  endtask

  task automatic add_frame(input logic [7:0] p, input logic [7:0] r,
                           input logic [7:0] d[$], input bit with_chk,
                           input logic [7:0] delta);
    logic [7:0] s;
    s = p + r;
    seq.push_back(ST);
    seq.push_back({2'b00, p});
    seq.push_back({2'b00, r});
    foreach (d[i]) begin
      seq.push_back({2'b00, d[i]});
      s = s + d[i];
    end
    if (CHK == 1 && with_chk) seq.push_back({2'b00, 8'(8'h00 - s + delta)});
    seq.push_back(EN);
  endtask

  // Bus monitor: collects accepted writes and pulses, checks stall stability.
  initial begin
    logic [23:0] prev_f;
    bit prev_st;
    prev_st = 1'b0;
    prev_f = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_st = 1'b0;
      end else begin
        if (prev_st) begin
          chk("stall_valid", 32'(wr_valid), 32'd1);
          chk("stall_fields", 32'({wr_periph, wr_reg, wr_data}), 32'(prev_f));
        end
        if (frame_ok || frame_err)
          chk("ok_err_excl", 32'(frame_ok & frame_err), 32'd0);
        if (wr_valid && wr_ready) got_w.push_back({wr_periph, wr_reg, wr_data});
        if (frame_ok) got_ok++;
        if (frame_err) got_ec++;
        prev_st = wr_valid && !wr_ready;
        prev_f = {wr_periph, wr_reg, wr_data};
      end
    end
  end

  initial begin
    wr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) wr_ready = 1'b1;
      else if (rdy_mode == 1) wr_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [7:0] d[$];
    int kind, n;
    reset = 1'b1;
    char_drdy = 1'b0;
    char_data = 8'h00;
    char_start = 1'b0;
    char_end = 1'b0;
    rdy_mode = 0;
    auto_wait = 1'b1;
    rand_hold = 1'b0;
    in_frame = 1'b0;
    tally_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(wr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ok", 32'(frame_ok), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_fields", 32'({wr_periph, wr_reg, wr_data}), 32'd0);

    // Raw frames whose last byte is the checksum in the checksum build.
    seq = '{ST, 10'h005, 10'h010, 10'h0AA, 10'h0BB, 10'h086, EN};
    play_seq();
    tally_check("chk_good");
    seq = '{ST, 10'h005, 10'h010, 10'h0AA, 10'h0BB, 10'h087, EN};
    play_seq();
    tally_check("chk_bad");

    // Register wrap with a three-cycle stall on the first write.
    rdy_mode = 2;
    wr_ready = 1'b0;
    auto_wait = 1'b0;
    d = '{8'h11, 8'h22};
    add_frame(8'h02, 8'hFF, d, 1'b1, 8'h00);
    play_seq();
    chk("stall_fld", 32'({wr_periph, wr_reg, wr_data}), 32'(exp_w[0]));
    repeat (2) begin
      @(negedge clk);
      chk("stall_fld", 32'({wr_periph, wr_reg, wr_data}), 32'(exp_w[0]));
    end
    @(posedge clk); #1 wr_ready = 1'b1;
    wait_idle("wrap");
    tally_check("wrap");
    rdy_mode = 0;
    auto_wait = 1'b1;

    // Restart mid-frame.
    seq = '{ST, 10'h003, 10'h004};
    d = '{8'h09};
    add_frame(8'h07, 8'h08, d, 1'b1, 8'h00);
    play_seq();
    tally_check("restart");

    // Overflow, trailing END ignored, then a normal frame.
    seq = '{ST, 10'h001, 10'h000};
    for (int i = 0; i < MAX_DATA + 2; i++) seq.push_back(10'(i + 1));
    seq.push_back(EN);
    play_seq();
    chk("ovf_busy", 32'(busy), 32'd0);
    d = '{8'h5A, 8'hC3, 8'h01};
    add_frame(8'h04, 8'h20, d, 1'b1, 8'h00);
    play_seq();
    tally_check("overflow");

    // Reset during a stalled replay.
    rdy_mode = 2;
    wr_ready = 1'b0;
    auto_wait = 1'b0;
    d = '{8'hAA, 8'hBB};
    add_frame(8'h01, 8'h05, d, 1'b1, 8'h00);
    play_seq();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rr_valid", 32'(wr_valid), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    in_frame = 1'b0;
    tally_clear();
    rdy_mode = 0;
    auto_wait = 1'b1;
    d = '{8'h03};
    add_frame(8'h01, 8'h02, d, 1'b1, 8'h00);
    play_seq();
    tally_check("after_rst");

    // Randomized frames, backpressure and held-high char_drdy.
    rdy_mode = 1;
    rand_hold = 1'b1;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 6);
      d.delete();
      if ($urandom_range(0, 3) == 0)
        seq.push_back($urandom_range(0, 1) ? EN : 10'($urandom_range(0, 255)));
      if (kind == 4) begin
        seq.push_back(ST);
        seq.push_back(10'($urandom_range(0, 255)));
      end
      if (kind == 6) begin
        seq.push_back(ST);
        seq.push_back(10'($urandom_range(0, 255)));
        seq.push_back(EN);
      end else begin
        if (kind == 1) n = 0;
        else if (kind == 2) n = DEPTH + 1 + $urandom_range(0, 2);
        else n = $urandom_range(1, MAX_DATA);
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        add_frame(8'($urandom), 8'($urandom), d, 1'b1,
                  (kind == 3) ? 8'($urandom_range(1, 255)) : 8'h00);
      end
      play_seq();
      tally_check("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
